// File: rtl/pwm_peripheral.sv
// =============================================================================
// pwm_peripheral : 16 outputs, each forced low, static high, or driven by one
//                  shared double-buffered 8-bit PWM waveform.
// Revision       : 1.0
// =============================================================================
`default_nettype none

module pwm_peripheral #(
  parameter int unsigned PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam logic [11:0] c_PRE_LAST = 12'(PRESCALE - 1);

  logic [11:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [7:0]  duty_sh_q, duty_sh_d;
  logic [15:0] out_q, out_d;
  logic        period_start_q, period_start_d;
  logic        tick;
  logic        wrap;
  logic        pwm_sig;
  logic [15:0] en_out;
  logic [15:0] en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  always_comb begin
    tick           = (pre_cnt_q == c_PRE_LAST);
    wrap           = tick && (pwm_cnt_q == 8'hFF);
    pre_cnt_d      = tick ? 12'd0 : (pre_cnt_q + 12'd1);
    pwm_cnt_d      = tick ? (pwm_cnt_q + 8'd1) : pwm_cnt_q;
    duty_sh_d      = wrap ? pwm_duty_cycle : duty_sh_q;
    // Waveform is taken from the next state so the first out value of a
    // period lands on the same clk as period_start.
    pwm_sig        = (duty_sh_d == 8'hFF) || (pwm_cnt_d < duty_sh_d);
    out_d          = en_out & (~en_pwm | {16{pwm_sig}});
    period_start_d = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q      <= 12'd0;
      pwm_cnt_q      <= 8'd0;
      duty_sh_q      <= 8'h00;
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_sh_q      <= duty_sh_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_peripheral.sv
// =============================================================================
// tb_pwm_peripheral : scoreboard bench for pwm_peripheral with PRESCALE = 4.
// Revision          : 1.0
// =============================================================================
`default_nettype none

module tb_pwm_peripheral;

  localparam int unsigned PRESCALE = 4;
  localparam int PERIOD = 256 * PRESCALE;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  pwm_peripheral #(.PRESCALE(PRESCALE)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          k        = 0;
  logic [7:0]  duty_m   = 8'h00;
  logic [16:0] sb_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Scoreboard drain: one expected {period_start, out} per clk edge.
  always @(posedge clk) begin
    logic [16:0] e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("cycle", {15'd0, period_start, out}, {15'd0, e});
    end
  end

  int hi_acc, ps_acc, first_ps, first_hi;

  // Called just after a negedge; predicts the next edge, then advances one clk.
  task automatic cycle();
    int         ph;
    logic       sig;
    logic [15:0] eo, ep;
    k++;
    ph = k % PERIOD;
    if (ph == 0) duty_m = pwm_duty_cycle;
    sig = (duty_m == 8'hFF) || ((ph / PRESCALE) < int'(duty_m));
    eo  = {en_reg_out_15_8, en_reg_out_7_0};
    ep  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    sb_q.push_back({(ph == 0), eo & (~ep | {16{sig}})});
    @(posedge clk);
    #2;
    if (out == 16'hFFFF) hi_acc++;
    if (period_start) begin
      ps_acc++;
      if (first_ps < 0) first_ps = k;
    end
    if (out[0] && first_hi < 0) first_hi = k;
    @(negedge clk);
  endtask

  task automatic run_until(input int target, output int hi, output int ps,
                           output int fps, output int fhi);
    hi_acc = 0; ps_acc = 0; first_ps = -1; first_hi = -1;
    while (k < target) cycle();
    hi = hi_acc; ps = ps_acc; fps = first_ps; fhi = first_hi;
  endtask

  task automatic set_en(input logic [15:0] eo, input logic [15:0] ep);
    {en_reg_out_15_8, en_reg_out_7_0} = eo;
    {en_reg_pwm_15_8, en_reg_pwm_7_0} = ep;
  endtask

  initial begin
    int hi, ps, fps, fhi, hi1;

    rst_n = 1'b0;
    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'hFF;
    repeat (3) @(posedge clk);
    #2;
    check("reset_out", {16'd0, out}, 32'h0);
    check("reset_ps", {31'd0, period_start}, 32'h0);

    @(negedge clk);
    set_en(16'hA55A, 16'h0000);
    rst_n = 1'b1;
    k = 0; duty_m = 8'h00;
    cycle();
    check("static_on", {16'd0, out}, 32'h0000A55A);
    set_en(16'h0000, 16'h0000);
    cycle();
    check("static_off", {16'd0, out}, 32'h0);

    set_en(16'hFFFF, 16'hFFFF);
    pwm_duty_cycle = 8'h80;
    run_until(PERIOD - 1, hi, ps, fps, fhi);
    check("p1_hi", hi, 0);
    check("p1_ps", ps, 0);
    run_until(2 * PERIOD - 1, hi, ps, fps, fhi);
    check("first_ps_k", fps, PERIOD);
    check("p50_hi", hi, 512);
    check("p50_rise_at_ps", fhi, fps);

    pwm_duty_cycle = 8'h00;
    run_until(5 * PERIOD - 1, hi, ps, fps, fhi);
    check("d00_hi", hi, 0);
    check("d00_ps", ps, 3);

    pwm_duty_cycle = 8'hFF;
    run_until(8 * PERIOD - 1, hi, ps, fps, fhi);
    check("dFF_hi", hi, 3 * PERIOD);
    check("dFF_ps", ps, 3);

    pwm_duty_cycle = 8'h01;
    run_until(9 * PERIOD - 1, hi, ps, fps, fhi);
    check("d01_hi", hi, 4);

    pwm_duty_cycle = 8'h40;
    run_until(10 * PERIOD - 1, hi, ps, fps, fhi);
    check("d40_hi", hi, 256);
    run_until(10 * PERIOD + 400, hi1, ps, fps, fhi);
    pwm_duty_cycle = 8'hC0;
    run_until(11 * PERIOD - 1, hi, ps, fps, fhi);
    check("dbuf_cur_hi", hi1 + hi, 256);
    check("dbuf_cur_tail", hi, 0);
    run_until(12 * PERIOD - 1, hi, ps, fps, fhi);
    check("dbuf_next_hi", hi, 768);
    check("dbuf_next_rise", fhi, fps);

    pwm_duty_cycle = 8'h80;
    run_until(12 * PERIOD + 100, hi, ps, fps, fhi);
    @(posedge clk);
    #2;
    check("pre_reset_hi", {16'd0, out}, 32'h0000FFFF);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {16'd0, out}, 32'h0);
    check("async_rst_ps", {31'd0, period_start}, 32'h0);
    repeat (3) begin
      @(posedge clk);
      #2;
      check("rst_hold_out", {16'd0, out}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    k = 0; duty_m = 8'h00;
    run_until(PERIOD - 1, hi, ps, fps, fhi);
    check("post_rst_p1_hi", hi, 0);
    run_until(2 * PERIOD - 1, hi, ps, fps, fhi);
    check("post_rst_p2_hi", hi, 512);
    check("post_rst_ps_k", fps, PERIOD);

    @(posedge clk);
    #3;
    check("sb_drain", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
